// File: rtl/eu_seq_if.sv
// eu_seq_if: request/response bundle for the eu_seq execution unit.
//   start/op/rd/a/b/ci : operation request, sampled by the unit while idle
//   busy/done          : unit occupied / one-cycle write-back pulse
//   result/hi          : last written value / high half (mul) or remainder (div)
//   cflag/dz           : carry/borrow of add/sub, divide-by-zero of last op
//   raddr/rdata        : combinational register-file read port
// The master modport is the requester; the slave modport is the unit.
interface eu_seq_if #(
  parameter int N  = 16,
  parameter int RW = 4
);
  logic          start;
  logic [1:0]    op;
  logic [RW-1:0] rd;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          ci;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic [N-1:0]  hi;
  logic          cflag;
  logic          dz;
  logic [RW-1:0] raddr;
  logic [N-1:0]  rdata;

  modport master (
    output start, op, rd, a, b, ci, raddr,
    input  busy, done, result, hi, cflag, dz, rdata
  );

  modport slave (
    input  start, op, rd, a, b, ci, raddr,
    output busy, done, result, hi, cflag, dz, rdata
  );
endinterface

// File: rtl/eu_seq.sv
// eu_seq: sequential execution unit with an NREG x N register file.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any op, clears all state)
//   bus   : eu_seq_if slave port (request, status/flags, regfile read port)
// Operations (unsigned, modulo 2^N): 00 add, 01 sub (single cycle),
// 10 mul (N-cycle shift-add), 11 div (N-cycle restoring; b==0 takes one cycle
// and yields quotient all ones, remainder a, dz=1).
// Sequence: IDLE -> EXEC -> WB -> IDLE. done is high during WB; the register
// write and the result/hi/cflag/dz update happen on the edge that ends WB.
module eu_seq #(
  parameter int N    = 16,
  parameter int NREG = 16,
  parameter int RW   = $clog2(NREG)
) (
  input  logic       clk,
  input  logic       rst_n,
  eu_seq_if.slave    bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                            OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  state_t        state;
  op_t           op_q;
  logic [RW-1:0] rd_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          ci_q;
  logic [CW-1:0] cnt;
  logic          c_q;
  logic          dz_q;
  logic [N-1:0]  regs [NREG];

  // Shared 2N-bit working register. mul: {partial product, multiplier};
  // div: {remainder, dividend/quotient}. add/sub and div-by-zero also park
  // their {hi, result} pair here so WB has a single source.
  logic [2*N-1:0] acc;

  logic [N:0]     addsub;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     rem_shift;
  logic           div_ge;
  logic [N-1:0]   div_diff;
  logic [2*N-1:0] div_next;

  always_comb begin
    addsub    = '0;
    mul_sum   = '0;
    mul_next  = '0;
    rem_shift = '0;
    div_ge    = 1'b0;
    div_diff  = '0;
    div_next  = '0;

    if (op_q == OP_SUB)
      addsub = {1'b0, a_q} - {1'b0, b_q} - {{N{1'b0}}, ci_q};
    else
      addsub = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, ci_q};

    // Shift-add step: add multiplicand when the multiplier LSB is set,
    // then shift the whole accumulator right, keeping the carry.
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc[N-1:1]};

    // Restoring step: bring in the next dividend bit; subtract the divisor
    // when it fits. The difference is below b, so N bits suffice.
    rem_shift = {acc[2*N-1:N], acc[N-1]};
    div_ge    = (rem_shift >= {1'b0, b_q});
    div_diff  = rem_shift[N-1:0] - b_q;
    if (div_ge)
      div_next = {div_diff, acc[N-2:0], 1'b1};
    else
      div_next = {acc[2*N-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ci_q       <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      c_q        <= 1'b0;
      dz_q       <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.hi     <= '0;
      bus.cflag  <= 1'b0;
      bus.dz     <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= op_t'(bus.op);
            rd_q     <= bus.rd;
            a_q      <= bus.a;
            b_q      <= bus.b;
            ci_q     <= bus.ci;
            cnt      <= CW'(N - 1);
            // mul iterates over the multiplier (b), div over the dividend (a)
            acc      <= (op_t'(bus.op) == OP_MUL) ? {{N{1'b0}}, bus.b}
                                                  : {{N{1'b0}}, bus.a};
            bus.busy <= 1'b1;
            state    <= EXEC;
          end
        end

        EXEC: begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              acc      <= {{N{1'b0}}, addsub[N-1:0]};
              c_q      <= addsub[N];
              dz_q     <= 1'b0;
              bus.done <= 1'b1;
              state    <= WB;
            end
            OP_MUL: begin
              acc  <= mul_next;
              c_q  <= 1'b0;
              dz_q <= 1'b0;
              if (cnt == '0) begin
                bus.done <= 1'b1;
                state    <= WB;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            OP_DIV: begin
              c_q <= 1'b0;
              if (b_q == '0) begin
                acc      <= {a_q, {N{1'b1}}};
                dz_q     <= 1'b1;
                bus.done <= 1'b1;
                state    <= WB;
              end else begin
                acc  <= div_next;
                dz_q <= 1'b0;
                if (cnt == '0) begin
                  bus.done <= 1'b1;
                  state    <= WB;
                end else begin
                  cnt <= cnt - 1'b1;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end

        WB: begin
          regs[rd_q] <= acc[N-1:0];
          bus.result <= acc[N-1:0];
          bus.hi     <= acc[2*N-1:N];
          bus.cflag  <= c_q;
          bus.dz     <= dz_q;
          bus.done   <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rdata = regs[bus.raddr];
  end
endmodule

// File: tb/tb_eu_seq.sv
// tb_eu_seq: self-checking bench for eu_seq. A behavioural model tracks the
// unit in terms of accept edges and write-back edges and computes results
// with plain integer arithmetic; every cycle the DUT outputs are compared to
// it. Directed cases with literal expectations pin the model, then a long
// randomized run exercises back-to-back ops, start-while-busy and div-by-0.
module tb_eu_seq;
  localparam int N    = 16;
  localparam int NREG = 16;
  localparam int RW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eu_seq_if #(.N(N), .RW(RW)) bus ();

  eu_seq #(.N(N), .NREG(NREG), .RW(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  longint       cyc = 0;
  bit           m_busy;
  longint       m_wb;
  logic [N-1:0] m_res, m_hi;
  bit           m_c, m_dz;
  logic [N-1:0] m_regs [NREG];
  logic [N-1:0] p_res, p_hi;
  bit           p_c, p_dz;
  logic [RW-1:0] p_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wb = 0; m_res = '0; m_hi = '0; m_c = 0; m_dz = 0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
  endtask

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_update();
    logic [N:0]     t;
    logic [2*N-1:0] pr;
    int             lat;
    cyc++;
    if (!rst_n) return;
    if (m_busy && cyc == m_wb) begin
      m_regs[p_rd] = p_res;
      m_res = p_res; m_hi = p_hi; m_c = p_c; m_dz = p_dz;
      m_busy = 0;
    end else if (!m_busy && bus.start) begin
      p_rd = bus.rd; p_c = 0; p_dz = 0; p_hi = '0; lat = 2;
      case (bus.op)
        2'b00: begin
          t = {1'b0, bus.a} + {1'b0, bus.b} + (N+1)'(bus.ci);
          p_res = t[N-1:0]; p_c = t[N];
        end
        2'b01: begin
          t = {1'b0, bus.a} - {1'b0, bus.b} - (N+1)'(bus.ci);
          p_res = t[N-1:0]; p_c = t[N];
        end
        2'b10: begin
          pr = (2*N)'(bus.a) * (2*N)'(bus.b);
          p_res = pr[N-1:0]; p_hi = pr[2*N-1:N]; lat = N + 1;
        end
        default: begin
          if (bus.b == '0) begin
            p_res = '1; p_hi = bus.a; p_dz = 1;
          end else begin
            p_res = bus.a / bus.b; p_hi = bus.a % bus.b; lat = N + 1;
          end
        end
      endcase
      m_busy = 1;
      m_wb = cyc + lat;
    end
  endtask

  task automatic compare_all();
    chk("busy",   bus.busy,   m_busy);
    chk("done",   bus.done,   (m_busy && cyc == m_wb - 1));
    chk("result", bus.result, m_res);
    chk("hi",     bus.hi,     m_hi);
    chk("cflag",  bus.cflag,  m_c);
    chk("dz",     bus.dz,     m_dz);
    chk("rdata",  bus.rdata,  m_regs[bus.raddr]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input logic [RW-1:0] rd);
    bus.op = op; bus.a = a; bus.b = b; bus.ci = ci; bus.rd = rd; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  // Called in the first cycle after accept; measures cycles until done,
  // then steps past the write-back edge.
  task automatic wait_done(input string name, input int exp_lat);
    int n = 1;
    while (bus.done !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    chk(name, n, exp_lat);
    cycle();
  endtask

  task automatic peek(input string name, input logic [RW-1:0] addr, input logic [N-1:0] exp);
    bus.raddr = addr;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  initial begin
    bus.start = 0; bus.op = 0; bus.rd = 0; bus.a = 0; bus.b = 0; bus.ci = 0; bus.raddr = 0;
    model_reset();
    repeat (3) cycle();
    // Reset state: every register reads zero, unit idle
    for (int i = 0; i < NREG; i++) peek("reset_reg", RW'(i), '0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    rst_n = 1'b1;
    cycle();

    // add with carry-out
    issue(2'b00, 16'hFFFF, 16'h0001, 1'b0, 4'd3);
    wait_done("add_lat", 2);
    peek("add_reg3", 4'd3, 16'h0000);
    chk("add_cflag", bus.cflag, 1'b1);
    cycle();

    // sub with borrow
    issue(2'b01, 16'd5, 16'd7, 1'b0, 4'd0);
    wait_done("sub_lat", 2);
    peek("sub_reg0", 4'd0, 16'hFFFE);
    chk("sub_cflag", bus.cflag, 1'b1);

    // mul
    issue(2'b10, 16'h1234, 16'h0100, 1'b1, 4'd15);
    wait_done("mul_lat", 17);
    chk("mul_result", bus.result, 16'h3400);
    chk("mul_hi", bus.hi, 16'h0012);
    chk("mul_cflag", bus.cflag, 1'b0);
    peek("mul_reg15", 4'd15, 16'h3400);

    // div and div by zero
    issue(2'b11, 16'd100, 16'd7, 1'b0, 4'd1);
    wait_done("div_lat", 17);
    peek("div_reg1", 4'd1, 16'd14);
    chk("div_hi", bus.hi, 16'd2);
    chk("div_dz", bus.dz, 1'b0);
    issue(2'b11, 16'd9, 16'd0, 1'b0, 4'd2);
    wait_done("div0_lat", 2);
    chk("div0_result", bus.result, 16'hFFFF);
    chk("div0_hi", bus.hi, 16'd9);
    chk("div0_dz", bus.dz, 1'b1);

    // start pulse while a mul is busy: ignored
    issue(2'b10, 16'd3, 16'd5, 1'b0, 4'd6);
    repeat (3) cycle();
    bus.op = 2'b00; bus.a = 16'd1; bus.b = 16'd1; bus.rd = 4'd7; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.a = 16'hAAAA; bus.b = 16'h5555;
    wait_done("ign_lat", 13);
    chk("ign_result", bus.result, 16'd15);
    peek("ign_reg6", 4'd6, 16'd15);
    peek("ign_reg7", 4'd7, 16'd0);
    chk("ign_busy", bus.busy, 1'b0);

    // reset in the middle of a mul: aborted, everything cleared
    issue(2'b10, 16'd7, 16'd9, 1'b0, 4'd5);
    repeat (5) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_result", bus.result, 16'd0);
    chk("abort_hi", bus.hi, 16'd0);
    chk("abort_dz", bus.dz, 1'b0);
    peek("abort_reg15", 4'd15, 16'd0);
    repeat (20) cycle();
    peek("abort_reg5", 4'd5, 16'd0);
    rst_n = 1'b1;
    cycle();

    // randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = N'($urandom);
      bus.b     = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      bus.ci    = 1'($urandom_range(0, 1));
      bus.rd    = RW'($urandom_range(0, NREG - 1));
      bus.raddr = RW'($urandom_range(0, NREG - 1));
      cycle();
    end
    bus.start = 1'b0;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
